// File: rtl/onehot_scan_decoder_if.sv
// Control/status bundle for onehot_scan_decoder: mode/select/dwell inputs
// and the registered one-hot, index and wrap outputs.
interface onehot_scan_decoder_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 1 << SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               load;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   dec_out;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (
        output en, mode, sel, load, dwell,
        input  dec_out, idx, wrap
    );

    modport slave (
        input  en, mode, sel, load, dwell,
        output dec_out, idx, wrap
    );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with an auto-scan mode that steps the
// index through every output line, holding each for dwell+1 cycles.
module onehot_scan_decoder #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_scan_decoder_if.slave  bus
);
    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d, dcnt_cur;
    logic [OUT_W-1:0]   dec_q, dec_d;
    logic               wrap_q, wrap_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d  = IDLE;
        idx_d    = idx_q;
        dcnt_d   = dcnt_q;
        wrap_d   = 1'b0;
        dec_d    = '0;
        // Coming out of DIRECT, the scan always begins with a fresh dwell count.
        dcnt_cur = (state_q == DIRECT) ? '0 : dcnt_q;

        if (bus.en) begin
            state_d = bus.mode ? SCAN : DIRECT;
        end

        case (state_d)
            DIRECT: begin
                idx_d  = bus.sel;
                dcnt_d = '0;
            end
            SCAN: begin
                if (bus.load) begin
                    idx_d  = bus.sel;
                    dcnt_d = '0;
                end else if (dcnt_cur >= bus.dwell) begin
                    // >= rather than == so a dwell reduced below the count ends the hold at once.
                    idx_d  = idx_q + 1'b1;
                    dcnt_d = '0;
                    wrap_d = &idx_q;
                end else begin
                    dcnt_d = dcnt_cur + 1'b1;
                end
            end
            default: ;
        endcase

        if (state_d != IDLE) begin
            dec_d = OUT_W'(1) << idx_d;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dcnt_q  <= '0;
            dec_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
            dec_q   <= dec_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.dec_out = dec_q;
    assign bus.idx     = idx_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder (SEL_W=2, DWELL_W=8) with
// hand-computed expectations for direct, scan, load, enable and reset cases.
module tb_onehot_scan_decoder;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    onehot_scan_decoder_if #(.SEL_W(2), .DWELL_W(8)) bus ();

    onehot_scan_decoder #(.SEL_W(2), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] dec, input logic [1:0] ix, input logic wr);
        check({tag, ".dec"},  32'(bus.dec_out), 32'(dec));
        check({tag, ".idx"},  32'(bus.idx),     32'(ix));
        check({tag, ".wrap"}, 32'(bus.wrap),    32'(wr));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] scan0_dec  [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] scan0_idx  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       scan0_wrap [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.en    = 1'b0;
        bus.mode  = 1'b0;
        bus.sel   = 2'd0;
        bus.load  = 1'b0;
        bus.dwell = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_out("idle_after_reset", 4'b0000, 2'd0, 1'b0);

        // Direct decode, one-cycle latency.
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sel = 2'(i);
            tick();
            check_out($sformatf("direct%0d", i), 4'(1 << i), 2'(i), 1'b0);
        end

        // Scan, dwell=0: preload 0 then advance every cycle.
        bus.mode  = 1'b1;
        bus.load  = 1'b1;
        bus.sel   = 2'd0;
        bus.dwell = 8'd0;
        tick();
        check_out("scan0_load", 4'b0001, 2'd0, 1'b0);
        bus.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("scan0_%0d", i), scan0_dec[i], scan0_idx[i], scan0_wrap[i]);
        end

        // Scan, dwell=3: 4 cycles per index, wrap once after 16 cycles.
        bus.load  = 1'b1;
        bus.sel   = 2'd0;
        bus.dwell = 8'd3;
        tick();
        check_out("scan3_load", 4'b0001, 2'd0, 1'b0);
        bus.load = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_out($sformatf("scan3_%0d", k), 4'(1 << ((k / 4) % 4)), 2'((k / 4) % 4), (k == 16));
        end

        // dcnt reaches 2 at idx 0, then dwell drops to 1: advance on the next edge.
        repeat (2) tick();
        check_out("dwell_hold", 4'b0001, 2'd0, 1'b0);
        bus.dwell = 8'd1;
        tick();
        check_out("dwell_drop", 4'b0010, 2'd1, 1'b0);

        // Walk to idx 3 with dcnt=1, then load on the expiring edge.
        repeat (5) tick();
        check_out("pre_load", 4'b1000, 2'd3, 1'b0);
        bus.load = 1'b1;
        bus.sel  = 2'd2;
        tick();
        check_out("load_wins", 4'b0100, 2'd2, 1'b0);
        bus.load = 1'b0;
        tick();
        check_out("load_hold", 4'b0100, 2'd2, 1'b0);
        tick();
        check_out("load_next", 4'b1000, 2'd3, 1'b0);

        // en=0 at idx 1, dcnt 1; a concurrent load must be ignored.
        bus.dwell = 8'd3;
        bus.load  = 1'b1;
        bus.sel   = 2'd1;
        tick();
        bus.load = 1'b0;
        tick();
        check_out("pre_idle", 4'b0010, 2'd1, 1'b0);
        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.sel  = 2'd3;
        tick();
        check_out("idle0", 4'b0000, 2'd1, 1'b0);
        tick();
        check_out("idle1", 4'b0000, 2'd1, 1'b0);
        bus.en   = 1'b1;
        bus.load = 1'b0;
        tick();
        check_out("resume0", 4'b0010, 2'd1, 1'b0);
        tick();
        check_out("resume1", 4'b0010, 2'd1, 1'b0);
        tick();
        check_out("resume_adv", 4'b0100, 2'd2, 1'b0);

        // SCAN -> DIRECT, then DIRECT -> SCAN from idx 3 with dwell 0.
        bus.mode = 1'b0;
        bus.sel  = 2'd3;
        tick();
        check_out("to_direct", 4'b1000, 2'd3, 1'b0);
        bus.mode  = 1'b1;
        bus.dwell = 8'd0;
        tick();
        check_out("to_scan_wrap", 4'b0001, 2'd0, 1'b1);
        tick();
        check_out("to_scan_next", 4'b0010, 2'd1, 1'b0);

        // Asynchronous reset between edges during scan.
        bus.dwell = 8'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 4'b0000, 2'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        check_out("restart0", 4'b0001, 2'd0, 1'b0);
        repeat (3) tick();
        check_out("restart_adv", 4'b0010, 2'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Parametrised, registered binary-to-one-hot decoder with an auto-scan mode. In direct mode it decodes an SEL_W-bit select into a 2^SEL_W one-hot output with one cycle of latency. In scan mode an internal index steps through every output line, holding each line for a programmable dwell time. The block sits between control logic and multiplexed peripherals such as seven-segment digit enables, LED columns or time-sliced channel strobes.

## Interface
- SEL_W, 2, select/index width; output width is OUT_W = 2^SEL_W (legal range 1..6)
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- en  input  1  block enable; 0 forces the outputs low and freezes the counters
- mode  input  1  0 = direct decode, 1 = auto-scan
- sel  input  SEL_W  select value in direct mode; index preload value in scan mode
- load  input  1  scan mode only: loads sel into the index
- dwell  input  DWELL_W  extra cycles each index is held in scan mode (0 = advance every cycle)
- dec_out  output  OUT_W  registered one-hot decode of idx, or all-zero
- idx  output  SEL_W  registered current index
- wrap  output  1  one-cycle pulse when the scan index wraps from OUT_W-1 to 0

## Operation
- FSM states:
  - IDLE: entered when en=0.
  - DIRECT: entered when en=1 and mode=0.
  - SCAN: entered when en=1 and mode=1.
  - The state is re-evaluated every cycle from the sampled en and mode.
- IDLE:
  - Next-cycle dec_out = 0 and wrap = 0.
  - idx and the dwell counter hold their values.
- DIRECT:
  - Next-cycle idx = sel and dec_out = 1 << sel.
  - The dwell counter is cleared and wrap = 0.
  - load is ignored.
- SCAN: a dwell counter dcnt runs 0..dwell. Priority order is:
  - load=1: idx = sel, dcnt = 0, no wrap.
  - Else if dcnt >= dwell: idx = idx+1 modulo OUT_W and dcnt = 0. wrap = 1 only if the old idx was OUT_W-1.
  - Else dcnt = dcnt+1 and idx holds.
  - dec_out always equals 1 << idx on the same edge that idx updates.
- dwell is sampled live. The >= compare makes a reduced dwell take effect on the next cycle, and guarantees no count overrun.
- Transition DIRECT->SCAN: scanning starts from the current idx with dcnt = 0.
- Transition SCAN->DIRECT: takes effect on the next edge, and idx then follows sel.
- Transition to or from IDLE: on re-enable, the state continues from the frozen idx and dcnt. dec_out becomes non-zero on the first enabled edge.
- dec_out never has more than one bit set. It is all-zero only in IDLE and after reset.
- SEL_W=1 degenerates to a 1-to-2 decoder; scan mode then alternates between lines 0 and 1.

## Timing
- Reset (asynchronous, rst_n low) sets:
  - dec_out = 0, idx = 0, wrap = 0, dcnt = 0, state = IDLE.
  - These values hold until the first rising clk edge after rst_n deasserts.
- Reset asserted mid-scan clears all state immediately, without waiting for a clock edge.
- Direct-mode latency: sel sampled at edge N appears on dec_out and idx after edge N.
- Scan period per index: dwell+1 cycles. Full sweep: OUT_W*(dwell+1) cycles, with wrap high for exactly one cycle per sweep.
- wrap asserts together with the edge where idx becomes 0 and dec_out becomes 1.
- load is sampled at the edge. The preloaded idx appears after that edge and is held for a full dwell+1 cycles.
- Simultaneous load and dwell expiry: load wins and no advance or wrap occurs.
- Simultaneous en=0 and load: en wins and load is ignored.

## Test plan
- SEL_W=2, DWELL_W=8; reset, then direct mode with en=1 and sel = 0,1,2,3 on successive cycles:
  - Expected dec_out one cycle later: 0001, 0010, 0100, 1000.
  - wrap must stay 0 throughout.
- Scan mode, dwell=0: dec_out must cycle 0001, 0010, 0100, 1000, 0001 on successive cycles, with wrap = 1 only on the 1000->0001 edge.
- Scan mode, dwell=3:
  - Each index must be held exactly 4 cycles and the sweep must take 16 cycles.
  - Drop dwell to 1 while dcnt=2: idx must advance on the next edge.
- Scan mode, load with sel=2 on the same edge as dwell expiry:
  - idx must become 2 (dec_out 0100), with no wrap pulse.
  - idx must then hold for dwell+1 cycles.
- en=0 mid-scan at idx=1 with dcnt=1:
  - dec_out must read 0000 and idx must hold at 1.
  - After re-enable, idx must remain 1 for the remaining dwell cycles.
- rst_n pulsed low between clock edges during scan:
  - dec_out, idx and wrap must go to 0 immediately.
  - After release with en=1, mode=1, scanning must restart at idx=0.
